// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and result-stage beat states.
// Imported by the result queue and its bench.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } beat_e;

  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// ALU-side push port and bus-side beat port of the result queue.
// slave = the queue, master = the ALU/bus environment.
interface alu_result_queue_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_hi;
  logic [DW-1:0] alu_lo;
  logic          bus_valid;
  logic          bus_ack;
  logic [DW-1:0] bus_data;
  logic          bus_last;
  logic          flag_zero;
  logic          flag_neg;
  logic          drop_err;

  modport slave (
    input  alu_valid, alu_op, alu_hi, alu_lo, bus_ack,
    output alu_ready, bus_valid, bus_data, bus_last,
    output flag_zero, flag_neg, drop_err
  );

  modport master (
    output alu_valid, alu_op, alu_hi, alu_lo, bus_ack,
    input  alu_ready, bus_valid, bus_data, bus_last,
    input  flag_zero, flag_neg, drop_err
  );
endinterface

// File: rtl/result_fifo.sv
// Generic DEPTH x W register FIFO; caller never pushes
// when full nor pops when empty.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Occupancy next state; simultaneous push/pop holds it.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/alu_result_queue.sv
// ALU result stage: queues results with flags and
// serialises them as LO/HI beats onto the bus.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input logic          clk,
  input logic          clr,
  alu_result_queue_if.slave q
);
  typedef struct packed {
    logic [4:0]    op;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          zero;
    logic          neg;
    logic          wide;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t wr_e, rd_e;
  logic   full, empty, push, pop;
  logic   drop_q;
  beat_e  state_q, state_d;
  logic   unused_op;

  // Capture-side entry: flags computed once at push.
  always_comb begin
    wr_e      = '0;
    wr_e.op   = q.alu_op;
    wr_e.wide = is_wide(q.alu_op);
    wr_e.lo   = q.alu_lo;
    wr_e.hi   = wr_e.wide ? q.alu_hi : '0;
    wr_e.zero = wr_e.wide ? ({q.alu_hi, q.alu_lo} == '0)
                          : (q.alu_lo == '0);
    wr_e.neg  = wr_e.wide ? q.alu_hi[DW-1]
                          : q.alu_lo[DW-1];
  end

  assign push = q.alu_valid & ~full;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (clr),
    .push_i  (push),
    .data_i  (wr_e),
    .pop_i   (pop),
    .data_o  (rd_e),
    .full_o  (full),
    .empty_o (empty)
  );

  assign unused_op = ^rd_e.op;

  // Beat FSM next state and pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (!empty && q.bus_ack) begin
      unique case (1'b1)
        (state_q == S_LO): begin
          if (rd_e.wide) state_d = S_HI;
          else           pop     = 1'b1;
        end
        (state_q == S_HI): begin
          pop     = 1'b1;
          state_d = S_LO;
        end
        default: state_d = S_LO;
      endcase
    end
  end

  // Beat state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_LO;
    else      state_q <= state_d;
  end

  // Sticky overflow flag: push attempted while full.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) drop_q <= 1'b0;
    else      drop_q <= drop_q | (q.alu_valid & full);
  end

  assign q.alu_ready = ~full;
  assign q.bus_valid = ~empty;
  assign q.bus_data  = empty ? '0
                     : (state_q == S_HI) ? rd_e.hi : rd_e.lo;
  assign q.bus_last  = ~empty &
                       ((state_q == S_HI) | ~rd_e.wide);
  assign q.flag_zero = ~empty & rd_e.zero;
  assign q.flag_neg  = ~empty & rd_e.neg;
  assign q.drop_err  = drop_q;
endmodule
